eth_rx_frame_buffer: RTL and testbench

// CPU-side consumer of the EMAC receive FIFO AXI-Stream (byte-wide, cpu_clk domain).

---
 rtl/eth_rx_frame_buffer.sv | 155 +++++++++++++++
 tb/tb_eth_rx_frame_buffer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_rx_frame_buffer.sv
// Receive frame buffer writer: packs AXI-Stream bytes into 32-bit RAM words, one frame at a time.
// RAM write lands one cycle after the completing byte; tready drops while a finished frame awaits ack.
module eth_rx_frame_buffer #(
   parameter int ADDR_W    = 9,
   parameter int MAX_BYTES = 1522
) (
   input  logic              cpu_clk,
   input  logic              glbl_rstn,
   input  logic [7:0]        rx_axis_tdata,
   input  logic              rx_axis_tvalid,
   output logic              rx_axis_tready,
   input  logic              rx_axis_tlast,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [3:0]        mem_be,
   output logic              frame_valid,
   output logic [10:0]       frame_len,
   input  logic              frame_ack,
   output logic [15:0]       drop_cnt
);

   typedef enum logic [1:0] {IDLE, RECV, DROP, DONE} state_t;

   state_t      state_q, state_d;
   logic        rdy_en;
   logic [10:0] byte_cnt;
   logic [31:0] pack;

   logic        xfer;
   logic        wr_word;
   logic        ovf;
   logic        done_frame;
   logic [10:0] cnt_cur;
   logic [10:0] cnt_nxt;
   logic [1:0]  lane;
   logic [31:0] word_dat;
   logic [3:0]  lane_be;

   // rdy_en keeps tready low while reset is asserted and releases it one cycle later
   assign rx_axis_tready = rdy_en && (state_q != DONE);
   assign xfer           = rx_axis_tvalid && rx_axis_tready;
   assign cnt_cur        = (state_q == IDLE) ? 11'd0 : byte_cnt;
   assign cnt_nxt        = cnt_cur + 11'd1;
   assign lane           = cnt_cur[1:0];
   assign word_dat       = pack | ({24'd0, rx_axis_tdata} << {lane, 3'b000});

   always_comb begin
      lane_be = 4'b0001;
      case (lane)
         2'd0:    lane_be = 4'b0001;
         2'd1:    lane_be = 4'b0011;
         2'd2:    lane_be = 4'b0111;
         default: lane_be = 4'b1111;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      wr_word    = 1'b0;
      ovf        = 1'b0;
      done_frame = 1'b0;
      case (state_q)
         IDLE: begin
            if (xfer) begin
               if (rx_axis_tlast) begin
                  wr_word    = 1'b1;
                  done_frame = 1'b1;
                  state_d    = DONE;
               end else begin
                  state_d = RECV;
               end
            end
         end
         RECV: begin
            if (xfer) begin
               if (cnt_cur == 11'(MAX_BYTES)) begin
                  // byte MAX_BYTES+1: frame is oversize, this byte is never written
                  ovf     = 1'b1;
                  state_d = rx_axis_tlast ? IDLE : DROP;
               end else begin
                  wr_word = (lane == 2'd3) || rx_axis_tlast;
                  if (rx_axis_tlast) begin
                     done_frame = 1'b1;
                     state_d    = DONE;
                  end
               end
            end
         end
         DROP: begin
            if (xfer && rx_axis_tlast) begin
               state_d = IDLE;
            end
         end
         DONE: begin
            if (frame_ack) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge cpu_clk or negedge glbl_rstn) begin
      if (!glbl_rstn) begin
         state_q <= IDLE;
         rdy_en  <= 1'b0;
      end else begin
         state_q <= state_d;
         rdy_en  <= 1'b1;
      end
   end

   always_ff @(posedge cpu_clk or negedge glbl_rstn) begin
      if (!glbl_rstn) begin
         byte_cnt    <= '0;
         pack        <= '0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         mem_be      <= '0;
         frame_valid <= 1'b0;
         frame_len   <= '0;
         drop_cnt    <= '0;
      end else begin
         mem_we <= 1'b0;
         if (ovf) begin
            pack <= '0;
         end else if (xfer && ((state_q == IDLE) || (state_q == RECV))) begin
            byte_cnt <= cnt_nxt;
            if (wr_word) begin
               mem_we    <= 1'b1;
               mem_addr  <= ADDR_W'(cnt_cur >> 2);
               mem_wdata <= word_dat;
               mem_be    <= lane_be;
               pack      <= '0;
            end else begin
               pack <= word_dat;
            end
         end

         if (done_frame) begin
            frame_valid <= 1'b1;
            frame_len   <= cnt_nxt;
         end else if ((state_q == DONE) && frame_ack) begin
            frame_valid <= 1'b0;
         end

         if (ovf && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_eth_rx_frame_buffer.sv
// Bench for eth_rx_frame_buffer: expected RAM writes and frame lengths are queued at stimulus time
// and a negedge monitor pops and compares them as the DUT produces them.
module tb_eth_rx_frame_buffer;

   localparam int ADDR_W = 9;
   localparam int MAX    = 1522;

   logic              cpu_clk = 1'b0;
   logic              glbl_rstn;
   logic [7:0]        rx_axis_tdata;
   logic              rx_axis_tvalid;
   logic              rx_axis_tready;
   logic              rx_axis_tlast;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [3:0]        mem_be;
   logic              frame_valid;
   logic [10:0]       frame_len;
   logic              frame_ack;
   logic [15:0]       drop_cnt;

   eth_rx_frame_buffer #(.ADDR_W(ADDR_W), .MAX_BYTES(MAX)) dut (
      .cpu_clk        (cpu_clk),
      .glbl_rstn      (glbl_rstn),
      .rx_axis_tdata  (rx_axis_tdata),
      .rx_axis_tvalid (rx_axis_tvalid),
      .rx_axis_tready (rx_axis_tready),
      .rx_axis_tlast  (rx_axis_tlast),
      .mem_we         (mem_we),
      .mem_addr       (mem_addr),
      .mem_wdata      (mem_wdata),
      .mem_be         (mem_be),
      .frame_valid    (frame_valid),
      .frame_len      (frame_len),
      .frame_ack      (frame_ack),
      .drop_cnt       (drop_cnt)
   );

   always #5 cpu_clk = ~cpu_clk;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       dat;
      logic [3:0]        be;
   } wr_t;

   wr_t exp_wr[$];
   int  exp_len[$];
   int  checks   = 0;
   int  errors   = 0;
   int  we_count = 0;
   bit  prev_fv  = 1'b0;
   wr_t mon_e;

   task automatic check(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Reference packing: byte i of the frame lands in word i/4, lane i%4
   task automatic exp_frame(input int len, input int base, input bit complete);
      int  n, nw;
      wr_t e;
      n  = (len > MAX) ? MAX : len;
      nw = complete ? (n + 3) / 4 : n / 4;
      for (int w = 0; w < nw; w++) begin
         e.addr = ADDR_W'(w);
         e.dat  = '0;
         e.be   = '0;
         for (int k = 0; k < 4; k++) begin
            if (4 * w + k < n) begin
               e.dat[8*k +: 8] = 8'(base + 4 * w + k);
               e.be[k]         = 1'b1;
            end
         end
         exp_wr.push_back(e);
      end
      if (complete) exp_len.push_back(len);
   endtask

   task automatic send(input int len, input int base, input bit gaps, input bit last_en);
      int t;
      for (int i = 0; i < len; i++) begin
         if (gaps) begin
            while ($urandom_range(0, 1) == 1) begin
               rx_axis_tvalid = 1'b0;
               @(negedge cpu_clk);
            end
         end
         rx_axis_tvalid = 1'b1;
         rx_axis_tdata  = 8'(base + i);
         rx_axis_tlast  = last_en && (i == len - 1);
         t = 0;
         while (!rx_axis_tready && t < 3000) begin
            @(negedge cpu_clk);
            t++;
         end
         if (!rx_axis_tready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout byte=%0d tready=%0b required=1", i, rx_axis_tready);
            rx_axis_tvalid = 1'b0;
            rx_axis_tlast  = 1'b0;
            return;
         end
         @(negedge cpu_clk);
      end
      rx_axis_tvalid = 1'b0;
      rx_axis_tlast  = 1'b0;
   endtask

   task automatic ack_frame(input string name);
      int t;
      t = 0;
      while (!frame_valid && t < 200) begin
         @(negedge cpu_clk);
         t++;
      end
      check({name, "_valid"}, frame_valid, 1);
      if (frame_valid) begin
         frame_ack = 1'b1;
         @(negedge cpu_clk);
         frame_ack = 1'b0;
         check({name, "_released"}, frame_valid, 0);
         check({name, "_tready_after_ack"}, rx_axis_tready, 1);
      end
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, "_tready"}, rx_axis_tready, 0);
      check({name, "_mem_we"}, mem_we, 0);
      check({name, "_mem_addr"}, mem_addr, 0);
      check({name, "_mem_wdata"}, mem_wdata, 0);
      check({name, "_mem_be"}, mem_be, 0);
      check({name, "_frame_valid"}, frame_valid, 0);
      check({name, "_frame_len"}, frame_len, 0);
      check({name, "_drop_cnt"}, drop_cnt, 0);
   endtask

   always @(negedge cpu_clk) begin
      if (mem_we) begin
         we_count++;
         if (exp_wr.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write addr=%0h data=%08h be=%0h required=none",
                     mem_addr, mem_wdata, mem_be);
         end else begin
            mon_e = exp_wr.pop_front();
            check("wr_addr", mem_addr, mon_e.addr);
            check("wr_data", mem_wdata, mon_e.dat);
            check("wr_be", mem_be, mon_e.be);
         end
      end
      if (frame_valid && !prev_fv) begin
         if (exp_len.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame len=%0d required=none", frame_len);
         end else begin
            check("frame_len", frame_len, exp_len.pop_front());
         end
         check("frame_valid_with_last_we", mem_we, 1);
      end
      prev_fv = frame_valid;
   end

   initial begin
      #500000;
      $display("FAIL watchdog_timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int snap;
      glbl_rstn      = 1'b0;
      rx_axis_tvalid = 1'b0;
      rx_axis_tdata  = 8'h00;
      rx_axis_tlast  = 1'b0;
      frame_ack      = 1'b0;
      repeat (3) @(negedge cpu_clk);
      check_reset_outputs("rst");
      glbl_rstn = 1'b1;
      @(negedge cpu_clk);
      check("tready_after_rst", rx_axis_tready, 1);

      exp_frame(64, 0, 1);
      send(64, 0, 0, 1);
      ack_frame("f64");

      exp_frame(61, 0, 1);
      send(61, 0, 0, 1);
      ack_frame("f61");

      // oversize ending exactly on the first excess byte: straight back to IDLE
      exp_frame(1523, 0, 0);
      send(1523, 0, 0, 1);
      repeat (2) @(negedge cpu_clk);
      check("drop1_cnt", drop_cnt, 1);
      check("drop1_no_frame", frame_valid, 0);
      check("drop1_tready", rx_axis_tready, 1);

      // oversize running past the limit exercises the discard state
      exp_frame(1530, 5, 0);
      send(1530, 5, 0, 1);
      repeat (2) @(negedge cpu_clk);
      check("drop2_cnt", drop_cnt, 2);
      check("drop2_no_frame", frame_valid, 0);

      exp_frame(8, 8'h80, 1);
      send(8, 8'h80, 0, 1);
      exp_frame(5, 8'hA0, 1);
      fork
         send(5, 8'hA0, 0, 1);
         begin
            @(negedge cpu_clk);
            #1 snap = we_count;
            repeat (9) @(negedge cpu_clk);
            #1;
            check("done_tready_low", rx_axis_tready, 0);
            check("done_no_writes", we_count - snap, 0);
            check("done_frame_held", frame_valid, 1);
            check("done_len_held", frame_len, 8);
            frame_ack = 1'b1;
            @(negedge cpu_clk);
            frame_ack = 1'b0;
            check("done_released", frame_valid, 0);
         end
      join
      ack_frame("f2");

      exp_frame(100, 8'h10, 1);
      send(100, 8'h10, 0, 1);
      ack_frame("f100");
      exp_frame(100, 8'h10, 1);
      send(100, 8'h10, 1, 1);
      ack_frame("f100_gaps");

      exp_frame(30, 8'h55, 0);
      send(30, 8'h55, 0, 0);
      glbl_rstn = 1'b0;
      #1;
      check_reset_outputs("midrst");
      repeat (2) @(negedge cpu_clk);
      glbl_rstn = 1'b1;
      @(negedge cpu_clk);
      exp_frame(10, 8'hC0, 1);
      send(10, 8'hC0, 0, 1);
      ack_frame("f10");

      repeat (5) @(negedge cpu_clk);
      check("writes_outstanding", exp_wr.size(), 0);
      check("frames_outstanding", exp_len.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
